// File: rtl/apb_wdt32_pkg.sv
// rtl/apb_wdt32_pkg.sv - register map and constants shared by the watchdog RTL and bench
package apb_wdt32_pkg;

    localparam logic [7:0] OFF_LOAD   = 8'h00;
    localparam logic [7:0] OFF_VALUE  = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_PRESC  = 8'h0C;
    localparam logic [7:0] OFF_INTCLR = 8'h10;
    localparam logic [7:0] OFF_RIS    = 8'h14;
    localparam logic [7:0] OFF_LOCK   = 8'h18;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int CTRL_RSTEN = 2;

    localparam logic [31:0] DEFAULT_LOCK_KEY = 32'h1ACCE551;
    localparam logic [31:0] LOAD_RESET       = 32'hFFFFFFFF;

endpackage

// File: rtl/wdt_prescaler.sv
// rtl/wdt_prescaler.sv - free-running 0..presc counter emitting a one-cycle tick
module wdt_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i & ~clear_i & (cnt_q == presc_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_wdt32.sv
// rtl/apb_wdt32.sv - APB watchdog: prescaled down-counter, IRQ on first timeout, sticky reset on second
module apb_wdt32
    import apb_wdt32_pkg::*;
#(
    parameter int          PRESC_W  = 8,
    parameter logic [31:0] LOCK_KEY = DEFAULT_LOCK_KEY
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic [7:0]  PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        WDT_STALL,
    output logic        IRQ,
    output logic        WDT_RST
);

    logic [31:0]        load_q, load_d, value_q, value_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               ris_q, ris_d, locked_q, locked_d;
    logic               irq_q, irq_d, wdt_rst_q, wdt_rst_d;

    logic [7:0] addr;
    logic       wr, wr_cfg, ld_wr, ctrl_wr, presc_wr, clr_wr, lock_wr;
    logic       en_rise, en_fall, tick, tick_ok;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^PADDR[1:0];
    assign addr    = {PADDR[7:2], 2'b00};
    assign wr      = PSEL & PENABLE & PWRITE;
    assign wr_cfg  = wr & ~locked_q;
    assign ld_wr   = wr_cfg & (addr == OFF_LOAD);
    assign ctrl_wr = wr_cfg & (addr == OFF_CTRL);
    assign presc_wr = wr_cfg & (addr == OFF_PRESC);
    assign clr_wr  = wr_cfg & (addr == OFF_INTCLR);
    assign lock_wr = wr & (addr == OFF_LOCK);
    assign en_rise = ctrl_wr & PWDATA[CTRL_EN] & ~ctrl_q[CTRL_EN];
    assign en_fall = ctrl_wr & ~PWDATA[CTRL_EN];
    // A tick coinciding with a CTRL write that disables the watchdog is dropped.
    assign tick_ok = tick & ~en_fall;

    wdt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .enable_i(ctrl_q[CTRL_EN] & ~WDT_STALL),
        .clear_i (ld_wr | en_rise),
        .presc_i (presc_q),
        .tick_o  (tick)
    );

    always_comb begin
        load_d    = ld_wr    ? PWDATA                : load_q;
        ctrl_d    = ctrl_wr  ? PWDATA[2:0]           : ctrl_q;
        presc_d   = presc_wr ? PWDATA[PRESC_W-1:0]   : presc_q;
        locked_d  = lock_wr  ? (PWDATA != LOCK_KEY)  : locked_q;
        value_d   = value_q;
        ris_d     = ris_q;
        wdt_rst_d = wdt_rst_q;
        // Register writes take priority over a coincident tick.
        if (ld_wr) begin
            value_d = PWDATA;
        end else if (clr_wr) begin
            value_d = load_q;
            ris_d   = 1'b0;
        end else if (en_rise) begin
            value_d = load_q;
        end else if (tick_ok) begin
            if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
            end else begin
                value_d = load_q;
                if (!ris_q) begin
                    ris_d = 1'b1;
                end else if (ctrl_q[CTRL_RSTEN]) begin
                    wdt_rst_d = 1'b1;
                end
            end
        end
        irq_d = ris_d & ctrl_d[CTRL_IRQEN];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            load_q    <= LOAD_RESET;
            value_q   <= LOAD_RESET;
            ctrl_q    <= '0;
            presc_q   <= '0;
            ris_q     <= 1'b0;
            locked_q  <= 1'b0;
            irq_q     <= 1'b0;
            wdt_rst_q <= 1'b0;
        end else begin
            load_q    <= load_d;
            value_q   <= value_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            ris_q     <= ris_d;
            locked_q  <= locked_d;
            irq_q     <= irq_d;
            wdt_rst_q <= wdt_rst_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (addr)
                OFF_LOAD:  PRDATA = load_q;
                OFF_VALUE: PRDATA = value_q;
                OFF_CTRL:  PRDATA = {29'd0, ctrl_q};
                OFF_PRESC: PRDATA = {{(32-PRESC_W){1'b0}}, presc_q};
                OFF_RIS:   PRDATA = {31'd0, ris_q};
                OFF_LOCK:  PRDATA = {31'd0, locked_q};
                default:   PRDATA = '0;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign IRQ     = irq_q;
    assign WDT_RST = wdt_rst_q;

endmodule

// File: tb/tb_apb_wdt32.sv
// tb/tb_apb_wdt32.sv - self-checking bench for apb_wdt32
module tb_apb_wdt32;
    import apb_wdt32_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, WDT_STALL = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, IRQ, WDT_RST;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    bit          pready_low = 1'b0;

    typedef struct {
        bit          wr;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    always #5 PCLK = ~PCLK;

    apb_wdt32 dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PADDR    (PADDR),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .WDT_STALL(WDT_STALL),
        .IRQ      (IRQ),
        .WDT_RST  (WDT_RST)
    );

    always @(negedge PCLK) if (PREADY !== 1'b1) pready_low = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0; WDT_STALL = 0;
        PRESET = 1'b0;
        #1 PRESET = 1'b1;
        #2 PRESET = 1'b0;
        @(posedge PCLK); #1;
    endtask

    // Starts 1ns after an edge; the write commits on the second edge inside the task.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] got;
        PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
        exp_q.push_back(exp);
        #2 got = PRDATA;
        check(name, got, exp_q.pop_front());
        @(posedge PCLK); #1 PENABLE = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first_irq, first_rst;

        vecs[0]  = '{1'b0, 8'h00, 32'h0,        OFF_LOAD,  32'hFFFFFFFF};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,        OFF_VALUE, 32'hFFFFFFFF};
        vecs[2]  = '{1'b0, 8'h00, 32'h0,        OFF_CTRL,  32'h0};
        vecs[3]  = '{1'b0, 8'h00, 32'h0,        OFF_PRESC, 32'h0};
        vecs[4]  = '{1'b0, 8'h00, 32'h0,        OFF_RIS,   32'h0};
        vecs[5]  = '{1'b0, 8'h00, 32'h0,        OFF_LOCK,  32'h0};
        vecs[6]  = '{1'b0, 8'h00, 32'h0,        8'h1C,     32'h0};
        vecs[7]  = '{1'b1, OFF_LOAD,  32'h12345678, OFF_LOAD,  32'h12345678};
        vecs[8]  = '{1'b1, OFF_VALUE, 32'h00000055, OFF_VALUE, 32'h12345678};
        vecs[9]  = '{1'b1, OFF_PRESC, 32'h000001FF, OFF_PRESC, 32'h000000FF};
        vecs[10] = '{1'b1, OFF_CTRL,  32'h000000F8, OFF_CTRL,  32'h0};
        vecs[11] = '{1'b1, OFF_RIS,   32'h00000001, OFF_RIS,   32'h0};

        do_reset();
        check("reset_irq", {31'd0, IRQ}, 32'd0);
        check("reset_wdt_rst", {31'd0, WDT_RST}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) apb_write(vecs[i].waddr, vecs[i].wdata);
            apb_read($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        // First timeout: LOAD=5, PRESC=1 -> IRQ 12 cycles after CTRL commit
        do_reset();
        apb_write(OFF_LOAD, 32'd5);
        apb_write(OFF_PRESC, 32'd1);
        apb_write(OFF_CTRL, 32'd3);
        first_irq = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge PCLK); #1;
            if (IRQ && first_irq == 0) begin
                first_irq = k;
                break;
            end
        end
        check("irq_latency", first_irq, 32'd12);
        apb_read("value_reload", OFF_VALUE, 32'd5);
        apb_read("ris_set", OFF_RIS, 32'd1);
        check("no_wdt_rst_without_rsten", {31'd0, WDT_RST}, 32'd0);

        // Reset in the middle of a running count
        do_reset();
        apb_read("value_after_midreset", OFF_VALUE, 32'hFFFFFFFF);
        check("irq_after_midreset", {31'd0, IRQ}, 32'd0);

        // Escalation: IRQ at 4, WDT_RST at 8, sticky through CTRL=0
        apb_write(OFF_LOAD, 32'd3);
        apb_write(OFF_CTRL, 32'd7);
        first_irq = 0; first_rst = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge PCLK); #1;
            if (IRQ && first_irq == 0) first_irq = k;
            if (WDT_RST && first_rst == 0) first_rst = k;
        end
        check("esc_irq_cycle", first_irq, 32'd4);
        check("esc_rst_cycle", first_rst, 32'd8);
        apb_write(OFF_CTRL, 32'd0);
        repeat (4) @(posedge PCLK);
        #1;
        check("wdt_rst_sticky", {31'd0, WDT_RST}, 32'd1);
        do_reset();
        check("wdt_rst_cleared_by_preset", {31'd0, WDT_RST}, 32'd0);

        // Service: INTCLR commits on the same edge as the second zero tick
        apb_write(OFF_LOAD, 32'd3);
        apb_write(OFF_CTRL, 32'd7);
        first_irq = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge PCLK); #1;
            if (IRQ && first_irq == 0) first_irq = k;
        end
        check("svc_irq_cycle", first_irq, 32'd4);
        apb_write(OFF_INTCLR, 32'hA5A5A5A5);
        check("svc_no_wdt_rst", {31'd0, WDT_RST}, 32'd0);
        apb_read("svc_value", OFF_VALUE, 32'd3);
        apb_read("svc_ris_cleared", OFF_RIS, 32'd0);
        check("svc_no_wdt_rst_later", {31'd0, WDT_RST}, 32'd0);

        // Lock
        do_reset();
        apb_write(OFF_LOCK, 32'd0);
        apb_write(OFF_LOAD, 32'd7);
        apb_write(OFF_CTRL, 32'd1);
        apb_read("locked_load", OFF_LOAD, 32'hFFFFFFFF);
        apb_read("locked_ctrl", OFF_CTRL, 32'd0);
        apb_read("lock_reads_1", OFF_LOCK, 32'd1);
        apb_write(OFF_LOCK, 32'h1ACCE551);
        apb_write(OFF_LOAD, 32'd7);
        apb_read("unlocked_load", OFF_LOAD, 32'd7);
        apb_read("lock_reads_0", OFF_LOCK, 32'd0);

        // Stall freezes the count; release resumes one step per cycle
        do_reset();
        apb_write(OFF_LOAD, 32'd100);
        apb_write(OFF_CTRL, 32'd1);
        WDT_STALL = 1'b1;
        for (int i = 0; i < 5; i++) apb_read($sformatf("stall_value%0d", i), OFF_VALUE, 32'd100);
        WDT_STALL = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        apb_read("after_stall_value", OFF_VALUE, 32'd97);

        // Unmapped address
        apb_read("unmapped_read", 8'h40, 32'd0);
        apb_write(8'h40, 32'hDEADBEEF);
        apb_read("unmapped_wr_load", OFF_LOAD, 32'd100);
        apb_read("unmapped_wr_ctrl", OFF_CTRL, 32'd1);
        apb_read("unmapped_wr_presc", OFF_PRESC, 32'd0);
        apb_read("unmapped_wr_lock", OFF_LOCK, 32'd0);
        check("pready_always_high", {31'd0, pready_low}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_wdt32.md
Name: apb_wdt32

Overview:
Watchdog timer slave on the N15 APB southbridge, occupying a free APB slave slot alongside the UART/I2C/SPI/TMR32 peripherals. It consumes APB transfers from the AHB-to-APB bridge. A prescaled 32-bit down-counter raises an interrupt on first timeout and a sticky system-reset request on the second unserviced timeout. A lock register protects the configuration from runaway firmware.

Parameters:
PRESC_W, 8, prescaler register width (tick period = PRESC+1 PCLK cycles)
LOCK_KEY, 32'h1ACCE551, value written to LOCK to unlock configuration writes

Ports:
PCLK  in  1  APB clock; single clock domain
PRESET  in  1  asynchronous, active-high reset
PSEL  in  1  APB slave select
PADDR  in  8  byte address; bits [1:0] ignored
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  tied 1 (zero wait states)
WDT_STALL  in  1  debug halt; freezes prescaler and counter while 1
IRQ  out  1  timeout interrupt, level
WDT_RST  out  1  system-reset request, sticky high until PRESET

Behaviour:
- Reset values: LOAD=32'hFFFFFFFF, VALUE=32'hFFFFFFFF, CTRL=0, PRESC=0, prescaler count=0, RIS=0, locked=0, IRQ=0, WDT_RST=0, PRDATA=0.
- Register map:
  - 0x00 LOAD (rw).
  - 0x04 VALUE (ro).
  - 0x08 CTRL (rw): [0] EN, [1] IRQEN, [2] RSTEN.
  - 0x0C PRESC (rw, PRESC_W bits).
  - 0x10 INTCLR (wo): any data clears RIS and reloads VALUE from LOAD.
  - 0x14 RIS (ro): [0].
  - 0x18 LOCK: write LOCK_KEY -> locked=0; any other value -> locked=1; reads return {31'b0, locked}.
- APB:
  - Write commits on the cycle PSEL & PENABLE & PWRITE.
  - PRDATA is combinational from PADDR while PSEL=1 & PWRITE=0, and 0 otherwise.
  - Unmapped addresses read 0; writes to them are ignored.
  - Writes to ro registers are ignored.
- Lock: while locked=1, writes to LOAD, CTRL, PRESC and INTCLR are ignored. LOCK itself is always writable.
- Prescaler: counts 0..PRESC while EN=1 & WDT_STALL=0. A tick is generated in the cycle the count equals PRESC, and the count returns to 0. With PRESC=0, a tick occurs every cycle.
- Counter, evaluated on each tick:
  - VALUE != 0 -> VALUE decrements by 1.
  - VALUE == 0 & RIS=0 -> RIS <= 1 and VALUE <= LOAD.
  - VALUE == 0 & RIS=1 -> WDT_RST <= 1 if RSTEN=1; VALUE <= LOAD.
- First interrupt latency from EN rising with PRESC=p, LOAD=L: RIS rises (L+1)*(p+1) cycles after the CTRL write commit.
- EN 0->1 via a CTRL write: VALUE <= LOAD and prescaler count <= 0.
- LOAD write: also sets VALUE <= new value and prescaler count <= 0.
- EN=0: counter and prescaler hold; RIS holds.
- IRQ = RIS & IRQEN, registered in the same cycle as RIS (no extra stage).
- WDT_RST: once set, held until PRESET. Clearing RSTEN, EN or RIS does not deassert it.
- Simultaneous events:
  - INTCLR or LOAD write in the same cycle as a zero-count tick: the write wins (reload, RIS cleared, no WDT_RST).
  - CTRL write clearing EN in the same cycle as a tick: the tick is discarded.
- Reset mid-count: all state returns to reset values asynchronously.
- VALUE never wraps below 0. LOAD=0 times out on every tick.

Decomposition:
- Shared package apb_wdt32_pkg:
  - register offsets (LOAD..LOCK);
  - CTRL bit indices EN/IRQEN/RSTEN;
  - default LOCK_KEY;
  - reset value of LOAD.
- One sub-module, wdt_prescaler:
  - inputs: PCLK, PRESET, enable, clear, PRESC;
  - output: single-cycle tick.
- APB decode, registers and the down-counter live in apb_wdt32.

Test Plan:
- Reset: PRESET pulse -> read VALUE=32'hFFFFFFFF, CTRL=0, RIS=0, LOCK=0; IRQ=0, WDT_RST=0.
- Timeout IRQ: LOAD=5, PRESC=1, CTRL=3 -> RIS/IRQ rise exactly 12 cycles after the CTRL commit; VALUE reloads to 5; WDT_RST stays 0.
- Reset escalation: LOAD=3, PRESC=0, CTRL=7, no INTCLR -> IRQ at cycle 4, WDT_RST=1 at cycle 8; WDT_RST remains high after a CTRL=0 write, until PRESET.
- Service: as above, but INTCLR written in the same cycle as the second zero tick -> RIS=0, VALUE=3, WDT_RST never asserts.
- Lock: write LOCK=0, then LOAD=7 -> LOAD unchanged (0xFFFFFFFF). Write LOCK=32'h1ACCE551, then LOAD=7 -> LOAD reads 7, LOCK reads 0.
- Stall and unmapped: WDT_STALL=1 for 10 cycles while running -> VALUE is constant throughout. Read at 0x40 -> 0; write 0x40 -> no register changes; PREADY=1 throughout.
